dmem_responder: RTL and testbench

Multi-cycle data-memory responder answering the CPU's MEM-stage load/store requests over a valid/ready request channel and a valid/ready response channel. It replaces the single-cycle data memory once the pipeline stalls on memory. The block performs byte/half/word lane selection and sign/zero extension from funct3, and models a programmable access latency. It sits between the EX_MEM register outputs (address, store data, funct3, MemRead/MemWrite) and the MEM_WB load-data input.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 41 ++++
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, responder state type and byte-enable helper
// for the data-memory responder and its lane aligner.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] byte_en(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic [3:0] be;
        be = 4'b0000;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << a;
            F3_H, F3_HU: be = a[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load lane extraction with sign/zero extension and store
// data replication across byte lanes; purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sx;

    always_comb begin
        byte_sel   = 8'(rword >> {addr_lo, 3'b000});
        half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];
        // funct3[2] distinguishes the unsigned load variants
        sx         = ~funct3[2];
        load_data  = rword;
        store_data = wdata;
        unique case (funct3)
            F3_B, F3_BU: begin
                load_data  = {{24{sx & byte_sel[7]}}, byte_sel};
                store_data = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                load_data  = {{16{sx & half_sel[15]}}, half_sel};
                store_data = {2{wdata[15:0]}};
            end
            default: begin
                load_data  = rword;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle MEM-stage data memory on valid/ready channels.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          cur_we;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_f3;
    logic [AW-1:0] idx;
    logic [1:0]    lo, lo_al;
    logic          illegal, misal, bad;
    logic          commit, mem_we;
    logic [3:0]    be;
    logic [31:0]   bmask, rd_word;
    logic [31:0]   load_data, store_data;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    // With zero latency the commit happens on the accept edge, so the
    // live request is used instead of the not-yet-latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr[AW+1:0];
            cur_wdata = req_wdata;
            cur_f3    = req_funct3;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_f3    = f3_q;
        end
    end

    assign idx = cur_addr[AW+1:2];
    assign lo  = cur_addr[1:0];

    assign illegal = !(cur_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                   || (cur_we && cur_f3[2]);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misal = ((cur_f3 == F3_H || cur_f3 == F3_HU) && lo[0])
                 || (cur_f3 == F3_W && lo != 2'b00);
    assign lo_al = lo;
`else
    assign misal = 1'b0;
    always_comb begin
        lo_al = lo;
        if (cur_f3 == F3_H || cur_f3 == F3_HU) begin
            lo_al = {lo[1], 1'b0};
        end else if (cur_f3 == F3_W) begin
            lo_al = 2'b00;
        end
    end
`endif

    assign bad = illegal | misal;

    assign be      = byte_en(cur_f3, lo_al);
    assign bmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign rd_word = mem[idx];

    dmem_lane_align u_align (
        .funct3     (cur_f3),
        .addr_lo    (lo_al),
        .rword      (rd_word),
        .wdata      (cur_wdata),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    cnt_d   = LAT;
                    if (LAT == 4'd0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rsp_err_d   = bad;
            rsp_rdata_d = (bad || cur_we) ? 32'h0 : load_data;
        end
    end

    // Gating with reset keeps a store from landing while reset is held.
    assign mem_we = commit && cur_we && !bad && reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= (rd_word & ~bmask) | (store_data & bmask);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            f3_q        <= 3'b000;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, hand sequences and random
// requests checked against a byte-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int MEMB  = 4 * DEPTH;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk;
    int n_err;

    logic [7:0] mb [MEMB];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl [$];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, accesses aligned by size.
    task automatic model(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3,
                         output logic [31:0] rd, output logic er);
        int unsigned sz;
        int unsigned b;
        logic        sgn;
        logic        legal;
        logic [31:0] v;
        sz  = 0;
        sgn = 1'b0;
        case (f3)
            3'd0: begin sz = 1; sgn = 1'b1; end
            3'd1: begin sz = 2; sgn = 1'b1; end
            3'd2: sz = 4;
            3'd4: sz = 1;
            3'd5: sz = 2;
            default: sz = 0;
        endcase
        legal = (sz != 0) && !(we && sz != 4 && !sgn);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (legal && (a % sz) != 0) legal = 1'b0;
`endif
        rd = 32'h0;
        er = !legal;
        if (legal) begin
            b = a % MEMB;
            b = b - (b % sz);
            if (we) begin
                for (int k = 0; k < int'(sz); k++)
                    mb[b + k] = 8'(wd >> (8 * k));
            end else begin
                v = 32'h0;
                for (int k = 0; k < int'(sz); k++)
                    v = v | (32'(mb[b + k]) << (8 * k));
                if (sgn && sz < 4 && v[8 * sz - 1])
                    v = v | (32'hFFFFFFFF << (8 * sz));
                rd = v;
            end
        end
    endtask

    task automatic run_req(input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input int hold,
                           output logic [31:0] rd, output logic er);
        int          cyc;
        logic [31:0] rd0;
        rd  = 32'h0;
        er  = 1'b0;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'h1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'(rsp_valid), 32'h1);
            return;
        end
        chk("latency", 32'(cyc), 32'(LAT + 1));
        rd  = rsp_rdata;
        er  = rsp_err;
        rd0 = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'h1);
            chk("hold_rdata", rsp_rdata, rd0);
            chk("hold_req_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("back_to_idle", {30'h0, rsp_valid, req_ready}, 32'h1);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                input logic [31:0] erd, input logic eer);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.f3 = f3;
        v.exp_rd = erd; v.exp_er = eer;
        return v;
    endfunction

    initial begin
        logic [31:0] rd, erd;
        logic        er, eer;
        int          seen;
        n_chk = 0;
        n_err = 0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b0;
        reset      = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int w = 0; w < DEPTH; w++) begin
            logic [31:0] d;
            d = $urandom;
            model(1'b1, 32'(w * 4), d, 3'd2, erd, eer);
            run_req(1'b1, 32'(w * 4), d, 3'd2, 0, rd, er);
            chk("prefill_err", 32'(er), 32'(eer));
        end

        tbl.push_back(mk(1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 0));
        tbl.push_back(mk(0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 32'h13, 32'h0, 3'd0, 32'hFFFFFFDE, 0));
        tbl.push_back(mk(0, 32'h13, 32'h0, 3'd4, 32'h000000DE, 0));
        tbl.push_back(mk(0, 32'h12, 32'h0, 3'd1, 32'hFFFFDEAD, 0));
        tbl.push_back(mk(0, 32'h10, 32'h0, 3'd5, 32'h0000BEEF, 0));
        tbl.push_back(mk(1, 32'h11, 32'h55, 3'd0, 32'h0, 0));
        tbl.push_back(mk(0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
        tbl.push_back(mk(0, 32'h11, 32'h0, 3'd1, 32'h0, 1));
        tbl.push_back(mk(0, 32'h12, 32'h0, 3'd2, 32'h0, 1));
        tbl.push_back(mk(1, 32'h13, 32'h0, 3'd2, 32'h0, 1));
`else
        tbl.push_back(mk(0, 32'h11, 32'h0, 3'd1, 32'h000055EF, 0));
        tbl.push_back(mk(0, 32'h12, 32'h0, 3'd2, 32'hDEAD55EF, 0));
        tbl.push_back(mk(1, 32'h13, 32'h0, 3'd2, 32'h0, 0));
        tbl.push_back(mk(1, 32'h10, 32'hDEAD55EF, 3'd2, 32'h0, 0));
`endif
        tbl.push_back(mk(0, 32'h10, 32'h0, 3'd3, 32'h0, 1));
        tbl.push_back(mk(1, 32'h10, 32'h0, 3'd3, 32'h0, 1));
        tbl.push_back(mk(1, 32'h10, 32'h0, 3'd6, 32'h0, 1));
        tbl.push_back(mk(1, 32'h10, 32'h0, 3'd4, 32'h0, 1));
        tbl.push_back(mk(0, 32'h10, 32'h0, 3'd7, 32'h0, 1));
        tbl.push_back(mk(0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 0));
        tbl.push_back(mk(1, 32'h14, 32'h01020304, 3'd2, 32'h0, 0));
        tbl.push_back(mk(1, 32'h16, 32'hA5A5ABCD, 3'd1, 32'h0, 0));
        tbl.push_back(mk(0, 32'h14, 32'h0, 3'd2, 32'hABCD0304, 0));
        tbl.push_back(mk(0, 32'h16, 32'h0, 3'd1, 32'hFFFFABCD, 0));
        tbl.push_back(mk(0, 32'h16, 32'h0, 3'd5, 32'h0000ABCD, 0));
        tbl.push_back(mk(0, 32'h15, 32'h0, 3'd0, 32'h00000003, 0));
        tbl.push_back(mk(1, 32'h3FF, 32'h80, 3'd0, 32'h0, 0));
        tbl.push_back(mk(0, 32'h3FF, 32'h0, 3'd0, 32'hFFFFFF80, 0));
        tbl.push_back(mk(0, 32'h7FF, 32'h0, 3'd4, 32'h00000080, 0));
        tbl.push_back(mk(0, 32'h410, 32'h0, 3'd2, 32'hDEAD55EF, 0));
        tbl.push_back(mk(0, 32'hFFFFF010, 32'h0, 3'd2, 32'hDEAD55EF, 0));

        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, erd, eer);
            run_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, 0,
                    rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
        end

        model(1'b0, 32'h10, 32'h0, 3'd2, erd, eer);
        run_req(1'b0, 32'h10, 32'h0, 3'd2, 5, rd, er);
        chk("hold_final_rdata", rd, erd);

        model(1'b0, 32'h20, 32'h0, 3'd2, erd, eer);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = ~erd;
        req_funct3 = 3'd2;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("wrst_req_ready", 32'(req_ready), 32'h1);
        chk("wrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("wrst_rsp_rdata", rsp_rdata, 32'h0);
        chk("wrst_rsp_err", 32'(rsp_err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("wrst_no_rsp", 32'(seen), 32'h0);
        run_req(1'b0, 32'h20, 32'h0, 3'd2, 0, rd, er);
        chk("wrst_prior_data", rd, erd);
        chk("wrst_prior_err", 32'(er), 32'h0);

        for (int r = 0; r < 300; r++) begin
            logic        we;
            logic [31:0] a, wd;
            logic [2:0]  f3;
            we = 1'($urandom);
            a  = $urandom;
            wd = $urandom;
            f3 = 3'($urandom_range(0, 7));
            model(we, a, wd, f3, erd, eer);
            run_req(we, a, wd, f3, 0, rd, er);
            chk($sformatf("rnd%0d_rdata", r), rd, erd);
            chk($sformatf("rnd%0d_err", r), 32'(er), 32'(eer));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
